// File: rtl/window_3x3_gen.sv
// window_3x3_gen -- 3x3 sliding-window generator for raster video.
//
// The caller supplies one pixel column per cycle: the current line's pixel
// plus the two column-aligned pixels from the previous two lines. The block
// keeps the last three columns in a 3x3 register array. It emits a window
// only when all nine taps belong to the current frame and to the correct
// lines, so border windows are never produced.
//
// Ports
//   clk, rst        single clock; asynchronous active-high reset
//   i_valid         one column accepted per cycle when high
//   i_width/height  frame geometry, sampled at pixel (0,0) of each frame
//   i_data_r0..r2   newest line .. two lines earlier, same column
//   o_valid         o_window holds a complete in-frame window
//   o_window        element (r,c) at [DATA_WIDTH*(3*r+c) +: DATA_WIDTH]
//                   r=0 is the oldest row, c=0 is the leftmost column
//   o_col/o_row     centre coordinates of o_window
//   o_frame_done    pulses with the output of the frame's last pixel
module window_3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [15:0]             i_width,
    input  logic [15:0]             i_height,
    input  logic [DATA_WIDTH-1:0]   i_data_r0,
    input  logic [DATA_WIDTH-1:0]   i_data_r1,
    input  logic [DATA_WIDTH-1:0]   i_data_r2,
    output logic                    o_valid,
    output logic [9*DATA_WIDTH-1:0] o_window,
    output logic [15:0]             o_col,
    output logic [15:0]             o_row,
    output logic                    o_frame_done
);

    // [r][c] packing places element (r,c) at bit offset DATA_WIDTH*(3*r+c),
    // which is exactly the o_window layout.
    typedef logic [2:0][2:0][DATA_WIDTH-1:0] win_t;

    logic [15:0] col_q, col_d, row_q, row_d;
    logic [15:0] width_q, width_d, height_q, height_d;
    win_t        win_q, win_d;
    win_t        o_window_q, o_window_d;
    logic [15:0] o_col_q, o_col_d, o_row_q, o_row_d;
    logic        o_valid_q, o_valid_d;
    logic        o_frame_done_q, o_frame_done_d;

    logic        frame_start;
    logic [15:0] eff_w, eff_h;
    logic        last_col, last_row;

    // Zero-sized frames degenerate to a single pixel; oversize is clamped.
    function automatic logic [15:0] clamp_dim(input logic [15:0] v);
        if (v == 16'd0)
            return 16'd1;
        else if (32'(v) > MAX_WIDTH)
            return 16'(MAX_WIDTH);
        else
            return v;
    endfunction

    always_comb begin
        // The (0,0) pixel must already see the freshly sampled geometry,
        // otherwise a 1-wide line would not wrap on its first pixel.
        frame_start = (col_q == 16'd0) && (row_q == 16'd0);
        eff_w       = frame_start ? clamp_dim(i_width)  : width_q;
        eff_h       = frame_start ? clamp_dim(i_height) : height_q;
        last_col    = (col_q == eff_w - 16'd1);
        last_row    = (row_q == eff_h - 16'd1);

        col_d          = col_q;
        row_d          = row_q;
        width_d        = width_q;
        height_d       = height_q;
        win_d          = win_q;
        o_window_d     = o_window_q;
        o_col_d        = o_col_q;
        o_row_d        = o_row_q;
        o_valid_d      = 1'b0;
        o_frame_done_d = 1'b0;

        if (i_valid) begin
            width_d  = eff_w;
            height_d = eff_h;

            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = i_data_r2;
            win_d[1][2] = i_data_r1;
            win_d[2][2] = i_data_r0;

            o_window_d = win_d;
            o_col_d    = col_q - 16'd1;
            o_row_d    = row_q - 16'd1;
            // col>=2 guarantees the two older columns were accepted on this
            // same line, so stale previous-line columns never escape.
            o_valid_d      = (col_q >= 16'd2) && (row_q >= 16'd2);
            o_frame_done_d = last_col && last_row;

            if (last_col) begin
                col_d = 16'd0;
                row_d = last_row ? 16'd0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q          <= '0;
            row_q          <= '0;
            width_q        <= 16'd1;
            height_q       <= 16'd1;
            win_q          <= '0;
            o_window_q     <= '0;
            o_col_q        <= '0;
            o_row_q        <= '0;
            o_valid_q      <= 1'b0;
            o_frame_done_q <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            width_q        <= width_d;
            height_q       <= height_d;
            win_q          <= win_d;
            o_window_q     <= o_window_d;
            o_col_q        <= o_col_d;
            o_row_q        <= o_row_d;
            o_valid_q      <= o_valid_d;
            o_frame_done_q <= o_frame_done_d;
        end
    end

    assign o_valid      = o_valid_q;
    assign o_window     = o_window_q;
    assign o_col        = o_col_q;
    assign o_row        = o_row_q;
    assign o_frame_done = o_frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen. Each frame is a small image held in the bench;
// the three input rows are read straight from that image, and the expected
// window at centre (x-1,y-1) is the 3x3 block of the image around it.
module tb_window_3x3_gen;

    localparam int DW   = 8;
    localparam int MAXW = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [15:0]       i_width = 16'd4, i_height = 16'd3;
    logic [DW-1:0]     i_data_r0 = '0, i_data_r1 = '0, i_data_r2 = '0;
    logic              o_valid, o_frame_done;
    logic [9*DW-1:0]   o_window;
    logic [15:0]       o_col, o_row;

    window_3x3_gen #(.DATA_WIDTH(DW), .MAX_WIDTH(MAXW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .i_width(i_width), .i_height(i_height),
        .i_data_r0(i_data_r0), .i_data_r1(i_data_r1), .i_data_r2(i_data_r2),
        .o_valid(o_valid), .o_window(o_window), .o_col(o_col), .o_row(o_row),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int cmp_n = 0, fail_n = 0;

    // reference model state
    logic [7:0]  img [16][16];
    int          k = 0, fw = 1, fh = 1;
    bit          pattern = 1'b0;
    logic        exp_valid = 1'b0, exp_done = 1'b0, exp_wcare = 1'b1;
    logic [15:0] exp_col = '0, exp_row = '0;
    logic [71:0] exp_win = '0;

    // observation records
    int          obs_v = 0, obs_d = 0;
    bit          got_first = 1'b0;
    logic [71:0] first_win = '0, last_win = '0;
    logic [15:0] first_col = '0, first_row = '0, last_col = '0;
    logic        last_done = 1'b0;

    function automatic int clampv(input int v);
        if (v == 0) return 1;
        if (v > MAXW) return MAXW;
        return v;
    endfunction

    task automatic new_image();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = pattern ? 8'(y * 16 + x) : 8'($urandom);
    endtask

    task automatic clear_obs();
        obs_v = 0; obs_d = 0; got_first = 1'b0;
    endtask

    // One cycle: check the output produced by the previous cycle's input,
    // then drive this cycle's column and predict its output.
    task automatic tick(input bit v);
        @(negedge clk);
        cmp_n++;
        if (o_valid !== exp_valid || o_frame_done !== exp_done ||
            o_col !== exp_col || o_row !== exp_row ||
            (exp_wcare && o_window !== exp_win)) begin
            fail_n++;
            $display("FAIL out_cycle t=%0t: got v=%b d=%b c=%0d r=%0d w=%h want v=%b d=%b c=%0d r=%0d w=%h care=%b",
                     $time, o_valid, o_frame_done, o_col, o_row, o_window,
                     exp_valid, exp_done, exp_col, exp_row, exp_win, exp_wcare);
        end
        if (o_valid === 1'b1) begin
            obs_v++;
            if (!got_first) begin
                got_first = 1'b1;
                first_win = o_window; first_col = o_col; first_row = o_row;
            end
            last_win = o_window; last_col = o_col; last_done = o_frame_done;
        end
        if (o_frame_done === 1'b1) obs_d++;

        i_valid = v;
        if (v) begin
            int x, y;
            if (k == 0) begin
                fw = clampv(int'(i_width));
                fh = clampv(int'(i_height));
                new_image();
            end
            x = k % fw;
            y = k / fw;
            i_data_r0 = img[y][x];
            i_data_r1 = (y >= 1) ? img[y-1][x] : 8'($urandom);
            i_data_r2 = (y >= 2) ? img[y-2][x] : 8'($urandom);
            exp_valid = (x >= 2) && (y >= 2);
            exp_done  = (k == fw * fh - 1);
            exp_col   = 16'(x - 1);
            exp_row   = 16'(y - 1);
            exp_wcare = exp_valid;
            if (exp_valid)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        exp_win[8*(3*r+c) +: 8] = img[y-2+r][x-2+c];
            k = (k + 1) % (fw * fh);
        end else begin
            i_data_r0 = 8'($urandom);
            i_data_r1 = 8'($urandom);
            i_data_r2 = 8'($urandom);
            exp_valid = 1'b0;
            exp_done  = 1'b0;
        end
    endtask

    // mode 0: continuous, 1: every other cycle idle, 2: random stalls and
    // random mid-frame geometry changes (which must be ignored).
    task automatic run_frame(input int mode);
        int n = 0;
        bit v;
        do begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (n % 2 == 0);
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            if (mode == 2 && k != 0 && $urandom_range(0, 15) == 0) begin
                i_width  = 16'($urandom_range(0, 14));
                i_height = 16'($urandom_range(0, 7));
            end
            tick(v);
            n++;
        end while (!(v && k == 0) && n < 4000);
        if (n >= 4000) begin
            cmp_n++; fail_n++;
            $display("FAIL frame_timeout: got %0d cycles without frame end, want fewer than 4000", n);
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst = 1'b1;
        i_valid = 1'b1;
        #1;
        if (chk) begin
            cmp_n++;
            if (o_valid !== 1'b0 || o_frame_done !== 1'b0 || o_col !== 16'd0 ||
                o_row !== 16'd0 || o_window !== '0) begin
                fail_n++;
                $display("FAIL reset_async: got v=%b d=%b c=%0d r=%0d w=%h want all zero",
                         o_valid, o_frame_done, o_col, o_row, o_window);
            end
        end
        @(posedge clk); #1;
        cmp_n++;
        if (o_valid !== 1'b0 || o_frame_done !== 1'b0 || o_col !== 16'd0 ||
            o_row !== 16'd0 || o_window !== '0) begin
            fail_n++;
            $display("FAIL reset_hold: got v=%b d=%b c=%0d r=%0d w=%h want all zero",
                     o_valid, o_frame_done, o_col, o_row, o_window);
        end
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        k = 0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_wcare = 1'b1;
        exp_col = '0; exp_row = '0; exp_win = '0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tick(1'b0);
    endtask

    task automatic test_basic();
        pattern = 1'b1; i_width = 16'd4; i_height = 16'd3;
        clear_obs();
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== 2) begin fail_n++; $display("FAIL basic_count: got %0d want 2", obs_v); end
        cmp_n++; if (obs_d !== 1) begin fail_n++; $display("FAIL basic_done: got %0d want 1", obs_d); end
        cmp_n++; if (first_row !== 16'd1 || first_col !== 16'd1) begin fail_n++; $display("FAIL basic_first_pos: got r=%0d c=%0d want r=1 c=1", first_row, first_col); end
        cmp_n++; if (first_win[7:0] !== 8'h00) begin fail_n++; $display("FAIL basic_e00: got %h want 00", first_win[7:0]); end
        cmp_n++; if (first_win[39:32] !== 8'h11) begin fail_n++; $display("FAIL basic_e11: got %h want 11", first_win[39:32]); end
        cmp_n++; if (first_win[71:64] !== 8'h22) begin fail_n++; $display("FAIL basic_e22: got %h want 22", first_win[71:64]); end
        cmp_n++; if (last_col !== 16'd2 || last_win[71:64] !== 8'h23 || last_done !== 1'b1) begin fail_n++; $display("FAIL basic_second: got c=%0d e22=%h done=%b want c=2 e22=23 done=1", last_col, last_win[71:64], last_done); end
        pattern = 1'b0;
    endtask

    task automatic test_stall();
        pattern = 1'b1; i_width = 16'd4; i_height = 16'd3;
        clear_obs();
        run_frame(1);
        tick(1'b0);
        cmp_n++; if (obs_v !== 2 || obs_d !== 1) begin fail_n++; $display("FAIL stall_count: got v=%0d d=%0d want v=2 d=1", obs_v, obs_d); end
        cmp_n++; if (last_win[71:64] !== 8'h23) begin fail_n++; $display("FAIL stall_e22: got %h want 23", last_win[71:64]); end
        pattern = 1'b0;
    endtask

    task automatic test_width_change();
        i_width = 16'd4; i_height = 16'd3;
        clear_obs();
        for (int i = 0; i < 12; i++) begin
            if (i == 4) i_width = 16'd8;
            tick(1'b1);
        end
        tick(1'b0);
        cmp_n++; if (obs_v !== 2 || obs_d !== 1) begin fail_n++; $display("FAIL wchg_old: got v=%0d d=%0d want v=2 d=1", obs_v, obs_d); end
        clear_obs();
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== 6 || obs_d !== 1) begin fail_n++; $display("FAIL wchg_new: got v=%0d d=%0d want v=6 d=1", obs_v, obs_d); end
    endtask

    task automatic test_narrow();
        i_width = 16'd2; i_height = 16'd5;
        clear_obs();
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== 0 || obs_d !== 1) begin fail_n++; $display("FAIL narrow: got v=%0d d=%0d want v=0 d=1", obs_v, obs_d); end
    endtask

    task automatic test_reset_midframe();
        i_width = 16'd4; i_height = 16'd3;
        for (int i = 0; i < 5; i++) tick(1'b1);
        do_reset(1'b1);
        pattern = 1'b1;
        clear_obs();
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== 2 || obs_d !== 1) begin fail_n++; $display("FAIL rstmid_count: got v=%0d d=%0d want v=2 d=1", obs_v, obs_d); end
        cmp_n++; if (first_win[39:32] !== 8'h11 || last_win[71:64] !== 8'h23) begin fail_n++; $display("FAIL rstmid_win: got e11=%h e22=%h want 11 23", first_win[39:32], last_win[71:64]); end
        pattern = 1'b0;
    endtask

    task automatic test_back_to_back();
        i_width = 16'd5; i_height = 16'd4;
        clear_obs();
        run_frame(0);
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== 12 || obs_d !== 2) begin fail_n++; $display("FAIL b2b: got v=%0d d=%0d want v=12 d=2", obs_v, obs_d); end
    endtask

    task automatic test_clamp();
        i_width = 16'd40; i_height = 16'd3;
        clear_obs();
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== (MAXW - 2) || obs_d !== 1) begin fail_n++; $display("FAIL clamp_max: got v=%0d d=%0d want v=%0d d=1", obs_v, obs_d, MAXW - 2); end
        i_width = 16'd5; i_height = 16'd0;
        clear_obs();
        run_frame(0);
        tick(1'b0);
        cmp_n++; if (obs_v !== 0 || obs_d !== 1) begin fail_n++; $display("FAIL clamp_zero: got v=%0d d=%0d want v=0 d=1", obs_v, obs_d); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int want;
            i_width  = 16'($urandom_range(0, 12));
            i_height = 16'($urandom_range(0, 6));
            clear_obs();
            run_frame(2);
            tick(1'b0);
            want = (fw >= 3 && fh >= 3) ? (fw - 2) * (fh - 2) : 0;
            cmp_n++;
            if (obs_v !== want || obs_d !== 1) begin
                fail_n++;
                $display("FAIL random_frame%0d (%0dx%0d): got v=%0d d=%0d want v=%0d d=1", f, fw, fh, obs_v, obs_d, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_width_change();
        test_narrow();
        test_reset_midframe();
        test_back_to_back();
        test_clamp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
